// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM memory arbiter: FSM encoding, watchdog default,
// and the registered bus request bundle.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbIfBusy  = 2'd1,
    ArbMemBusy = 2'd2
  } arb_state_e;

  localparam logic [7:0] ArbTimeoutDefault = 8'd255;
  localparam logic [3:0] SelWord           = 4'b1111;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } bus_req_t;

  // True when this ack-less busy cycle is the one that makes the count reach limit.
  function automatic logic wd_expired(input logic [7:0] cnt, input logic [7:0] limit);
    return ({1'b0, cnt} + 9'd1) == {1'b0, limit};
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (IF, MEM) to one-port memory arbiter with fixed MEM priority,
// req/ack bus handshake, watchdog abort and combinational stall request.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = ArbTimeoutDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_o,
  output logic        err_o
);

  arb_state_e  state;
  logic [7:0]  wd_cnt;
  bus_req_t    bus_q;

  logic        mem_elig, if_elig;
  logic        expired, done;
  logic [31:0] rdata_c;

  // A port pulsing ready this cycle still holds its old address; don't re-grant it.
  assign mem_elig = mem_ce_i & ~mem_ready_o;
  assign if_elig  = if_ce_i  & ~if_ready_o;

  assign expired = ~bus_ack_i & wd_expired(wd_cnt, TIMEOUT);
  assign done    = (state != ArbIdle) & (bus_ack_i | expired);
  assign rdata_c = bus_ack_i ? bus_rdata_i : 32'h0;

  assign bus_we_o    = bus_q.we;
  assign bus_addr_o  = bus_q.addr;
  assign bus_wdata_o = bus_q.wdata;
  assign bus_sel_o   = bus_q.sel;

  assign stallreq_o = (mem_ce_i & ~mem_ready_o) | (if_ce_i & ~if_ready_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ArbIdle;
      wd_cnt      <= 8'd0;
      bus_q       <= '0;
      bus_req_o   <= 1'b0;
      if_data_o   <= 32'h0;
      if_ready_o  <= 1'b0;
      mem_rdata_o <= 32'h0;
      mem_ready_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      case (state)
        ArbIdle: begin
          if (mem_elig) begin
            bus_q     <= '{we: mem_we_i, addr: mem_addr_i, wdata: mem_wdata_i, sel: mem_sel_i};
            bus_req_o <= 1'b1;
            wd_cnt    <= 8'd0;
            state     <= ArbMemBusy;
          end else if (if_elig) begin
            bus_q     <= '{we: 1'b0, addr: if_addr_i, wdata: 32'h0, sel: SelWord};
            bus_req_o <= 1'b1;
            wd_cnt    <= 8'd0;
            state     <= ArbIfBusy;
          end
        end
        ArbIfBusy, ArbMemBusy: begin
          if (done) begin
            bus_req_o <= 1'b0;
            state     <= ArbIdle;
            if (expired) err_o <= 1'b1;
            if (state == ArbIfBusy) begin
              if_ready_o <= 1'b1;
              if_data_o  <= rdata_c;
            end else begin
              mem_ready_o <= 1'b1;
              if (!bus_q.we) mem_rdata_o <= rdata_c;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= ArbIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// two-port traffic scored against a transaction-level requester/memory model.
module tb_mem_arbiter;

  localparam logic [7:0] TO = 8'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_o;
  logic        err_o;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i),
    .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_o(stallreq_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;

  // memory responder state
  bit          in_txn, txn_start, no_ack, idle_ack, rand_dly, rd_ov_en;
  int          wt, ack_dly;
  logic [31:0] rd_ov;
  logic        t_we;
  logic [31:0] t_addr, t_wd;
  logic [3:0]  t_sel;
  int          n_if_rdy, n_mem_rdy;
  logic [31:0] exp_mrd;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  // One clock: advance, sample pulses, play the memory side for this cycle.
  task automatic cycle();
    @(posedge clk); #1;
    cyc++;
    txn_start = 1'b0;
    if (if_ready_o)  n_if_rdy++;
    if (mem_ready_o) n_mem_rdy++;
    if (bus_req_o) begin
      if (!in_txn) begin
        in_txn = 1'b1; txn_start = 1'b1; wt = 0;
        t_we = bus_we_o; t_addr = bus_addr_o; t_wd = bus_wdata_o; t_sel = bus_sel_o;
        if (rand_dly) ack_dly = $urandom_range(0, 2);
      end else begin
        checks++;
        if ({bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o} !== {t_we, t_addr, t_wd, t_sel}) begin
          errors++;
          $display("FAIL bus_hold cyc=%0d: got %h/%h/%h/%h want %h/%h/%h/%h", cyc,
                   bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, t_we, t_addr, t_wd, t_sel);
        end
      end
      if (!no_ack && wt == ack_dly) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = rd_ov_en ? rd_ov : mem_word(bus_addr_o);
      end else begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
        wt++;
      end
    end else begin
      in_txn      = 1'b0;
      bus_ack_i   = idle_ack ? 1'b1 : ($urandom_range(0, 3) == 0);
      bus_rdata_i = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_ce_i = 0; if_addr_i = 0; mem_ce_i = 0; mem_we_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0; mem_sel_i = 0;
    bus_ack_i = 0; bus_rdata_i = 0;
    cycle(); cycle();
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o} !== 70'h0) begin
      errors++; $display("FAIL reset_bus: got %h/%h/%h/%h/%h want 0", bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o);
    end
    checks++;
    if ({if_data_o, if_ready_o, mem_rdata_o, mem_ready_o} !== 66'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", if_data_o, if_ready_o, mem_rdata_o, mem_ready_o);
    end
    checks++;
    if ({err_o, stallreq_o} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got err=%b stall=%b want 0/0", err_o, stallreq_o);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_if_alone();
    int lat;
    logic [31:0] a;
    int d;
    ack_dly = 1; rd_ov_en = 1'b1; rd_ov = 32'h3401_0020;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0004;
    cycle();
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, stallreq_o, if_ready_o} !== {1'b1, 1'b0, 32'h4, 4'hF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL if_grant: got req=%b we=%b addr=%h sel=%h stall=%b rdy=%b want 1/0/4/f/1/0",
                         bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, stallreq_o, if_ready_o);
    end
    cycle();
    checks++;
    if ({bus_req_o, if_ready_o, stallreq_o} !== 3'b101) begin
      errors++; $display("FAIL if_wait: got req=%b rdy=%b stall=%b want 1/0/1", bus_req_o, if_ready_o, stallreq_o);
    end
    cycle();
    checks++;
    if ({if_ready_o, if_data_o, stallreq_o, bus_req_o} !== {1'b1, 32'h3401_0020, 1'b0, 1'b0}) begin
      errors++; $display("FAIL if_done: got rdy=%b data=%h stall=%b req=%b want 1/34010020/0/0",
                         if_ready_o, if_data_o, stallreq_o, bus_req_o);
    end
    if_ce_i = 1'b0; rd_ov_en = 1'b0;
    cycle();
    checks++;
    if (if_ready_o !== 1'b0) begin
      errors++; $display("FAIL if_pulse_width: got rdy=%b want 0", if_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      d = (i == 0) ? 0 : $urandom_range(0, 2);
      ack_dly = d; if_ce_i = 1'b1; if_addr_i = a; lat = 0;
      do begin cycle(); lat++; end while (!if_ready_o && lat < 20);
      checks++;
      if (lat != d + 2 || if_data_o !== mem_word(a)) begin
        errors++; $display("FAIL if_rand[%0d]: got lat=%0d data=%h want lat=%0d data=%h", i, lat, if_data_o, d + 2, mem_word(a));
      end
      if_ce_i = 1'b0;
      cycle();
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    int d1;
    d1 = $urandom_range(0, 2);
    ack_dly = d1;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h100; mem_wdata_i = 32'h0; mem_sel_i = 4'hF;
    if_ce_i = 1'b1; if_addr_i = 32'h8;
    cycle();
    checks++;
    if ({bus_req_o, bus_addr_o, bus_we_o} !== {1'b1, 32'h100, 1'b0}) begin
      errors++; $display("FAIL sim_mem_first: got req=%b addr=%h we=%b want 1/100/0", bus_req_o, bus_addr_o, bus_we_o);
    end
    lat = 1;
    while (!mem_ready_o && lat < 20) begin cycle(); lat++; end
    checks++;
    if (lat != d1 + 2 || mem_rdata_o !== mem_word(32'h100) || if_ready_o !== 1'b0) begin
      errors++; $display("FAIL sim_mem_done: got lat=%0d data=%h ifrdy=%b want lat=%0d data=%h ifrdy=0",
                         lat, mem_rdata_o, if_ready_o, d1 + 2, mem_word(32'h100));
    end
    exp_mrd = mem_word(32'h100);
    mem_ce_i = 1'b0;
    ack_dly = 0;
    cycle();
    checks++;
    if ({bus_req_o, bus_addr_o, bus_sel_o, bus_we_o} !== {1'b1, 32'h8, 4'hF, 1'b0}) begin
      errors++; $display("FAIL sim_if_next: got req=%b addr=%h sel=%h we=%b want 1/8/f/0", bus_req_o, bus_addr_o, bus_sel_o, bus_we_o);
    end
    lat = 0;
    do begin cycle(); lat++; end while (!if_ready_o && lat < 20);
    checks++;
    if (lat != 1 || if_data_o !== mem_word(32'h8)) begin
      errors++; $display("FAIL sim_if_done: got lat=%0d data=%h want lat=1 data=%h", lat, if_data_o, mem_word(32'h8));
    end
    if_ce_i = 1'b0;
    cycle();
  endtask

  task automatic test_mem_write();
    int lat, r0;
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    ack_dly = 3; r0 = n_mem_rdy;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_wdata_i = 32'hDEAD_BEEF; mem_addr_i = a;
    cycle();
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o} !== {1'b1, 1'b1, a, 32'hDEAD_BEEF, 4'b0011}) begin
      errors++; $display("FAIL wr_fields: got %b/%b/%h/%h/%h want 1/1/%h/deadbeef/3",
                         bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, a);
    end
    mem_ce_i = 1'b0;  // requester gives up; access must still finish
    lat = 1;
    while (!mem_ready_o && lat < 20) begin cycle(); lat++; end
    checks++;
    if (lat != 5 || mem_rdata_o !== exp_mrd || err_o !== 1'b0) begin
      errors++; $display("FAIL wr_done: got lat=%0d rdata=%h err=%b want lat=5 rdata=%h err=0", lat, mem_rdata_o, err_o, exp_mrd);
    end
    cycle(); cycle();
    checks++;
    if (n_mem_rdy - r0 != 1) begin
      errors++; $display("FAIL wr_pulses: got %0d want 1", n_mem_rdy - r0);
    end
    mem_we_i = 1'b0;
  endtask

  task automatic test_timeout();
    int nhi;
    no_ack = 1'b1;
    if_ce_i = 1'b1; if_addr_i = $urandom & 32'hFFFF_FFFC;
    nhi = 0;
    cycle();
    while (bus_req_o && nhi < 20) begin nhi++; cycle(); end
    checks++;
    if (nhi != 4 || if_ready_o !== 1'b1 || if_data_o !== 32'h0 || err_o !== 1'b1) begin
      errors++; $display("FAIL timeout: got busy=%0d rdy=%b data=%h err=%b want 4/1/0/1", nhi, if_ready_o, if_data_o, err_o);
    end
    if_ce_i = 1'b0; no_ack = 1'b0;
    cycle(); cycle(); cycle();
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err_o);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({err_o, if_data_o} !== 33'h0) begin
      errors++; $display("FAIL err_reset: got err=%b data=%h want 0/0", err_o, if_data_o);
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    int r0, lat;
    logic [31:0] b;
    ack_dly = 2;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h200; mem_sel_i = 4'hF;
    cycle();
    rst = 1'b1; mem_ce_i = 1'b0;
    cycle();
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, mem_ready_o, mem_rdata_o, if_data_o, err_o} !== 136'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got req=%b addr=%h rdy=%b rdata=%h want all 0", bus_req_o, bus_addr_o, mem_ready_o, mem_rdata_o);
    end
    rst = 1'b0; idle_ack = 1'b1; bus_ack_i = 1'b1;
    r0 = n_mem_rdy;
    cycle(); cycle(); cycle();
    idle_ack = 1'b0;
    checks++;
    if (n_mem_rdy != r0 || bus_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_noready: got pulses=%0d req=%b want 0/0", n_mem_rdy - r0, bus_req_o);
    end
    b = $urandom & 32'hFFFF_FFFC;
    ack_dly = 0; mem_ce_i = 1'b1; mem_addr_i = b; lat = 0;
    do begin cycle(); lat++; end while (!mem_ready_o && lat < 20);
    checks++;
    if (lat != 2 || mem_rdata_o !== mem_word(b)) begin
      errors++; $display("FAIL rst_mid_regrant: got lat=%0d data=%h want 2/%h", lat, mem_rdata_o, mem_word(b));
    end
    exp_mrd = mem_word(b);
    mem_ce_i = 1'b0;
    cycle();
  endtask

  task automatic test_repeat();
    int lat;
    logic [31:0] a1, a2;
    a1 = $urandom & 32'hFFFF_FFFC;
    a2 = a1 ^ 32'h0000_1000;
    ack_dly = $urandom_range(0, 2);
    if_ce_i = 1'b1; if_addr_i = a1; lat = 0;
    do begin cycle(); lat++; end while (!if_ready_o && lat < 20);
    checks++;
    if (if_data_o !== mem_word(a1)) begin
      errors++; $display("FAIL rep_first: got %h want %h", if_data_o, mem_word(a1));
    end
    if_addr_i = a2;
    cycle();
    checks++;
    if ({bus_req_o, if_ready_o} !== 2'b00) begin
      errors++; $display("FAIL rep_no_dup: got req=%b rdy=%b want 0/0", bus_req_o, if_ready_o);
    end
    cycle();
    checks++;
    if ({bus_req_o, bus_addr_o} !== {1'b1, a2}) begin
      errors++; $display("FAIL rep_regrant: got req=%b addr=%h want 1/%h", bus_req_o, bus_addr_o, a2);
    end
    lat = 0;
    while (!if_ready_o && lat < 20) begin cycle(); lat++; end
    checks++;
    if (if_ready_o !== 1'b1 || if_data_o !== mem_word(a2)) begin
      errors++; $display("FAIL rep_second: got rdy=%b data=%h want 1/%h", if_ready_o, if_data_o, mem_word(a2));
    end
    if_ce_i = 1'b0;
    cycle();
  endtask

  // Random traffic: each port issues, holds until its ready, may re-issue at once.
  task automatic test_back_to_back();
    bit          if_out, m_out, if_elig, m_elig, stop;
    logic [31:0] ra;
    logic        m_we;
    logic [31:0] ma, mwd;
    logic [3:0]  msel;
    int          if_age, m_age, n_issue, n_done, bad_stall, bad_sel;
    logic        exp_stall;
    rand_dly = 1'b1;
    if_out = 0; m_out = 0; if_elig = 0; m_elig = 0; stop = 0;
    if_age = 0; m_age = 0; n_issue = 0; n_done = 0; bad_stall = 0; bad_sel = 0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (c >= 360) stop = 1'b1;
      exp_stall = (mem_ce_i & ~mem_ready_o) | (if_ce_i & ~if_ready_o);
      if (stallreq_o !== exp_stall) bad_stall++;
      if (txn_start) begin
        checks++;
        if (m_elig) begin
          if ({t_we, t_addr, t_wd, t_sel} !== {m_we, ma, mwd, msel}) begin
            errors++; bad_sel++;
            $display("FAIL rnd_mem_grant cyc=%0d: got %b/%h/%h/%h want %b/%h/%h/%h", cyc, t_we, t_addr, t_wd, t_sel, m_we, ma, mwd, msel);
          end
        end else if (!if_elig || {t_we, t_addr, t_sel} !== {1'b0, ra, 4'hF}) begin
          errors++; bad_sel++;
          $display("FAIL rnd_if_grant cyc=%0d: got %b/%h/%h want if_elig=1 0/%h/f (elig=%b)", cyc, t_we, t_addr, t_sel, ra, if_elig);
        end
      end
      if (if_ready_o) begin
        checks++;
        if (!if_out || if_data_o !== mem_word(ra)) begin
          errors++; $display("FAIL rnd_if_ready cyc=%0d: got out=%b data=%h want 1/%h", cyc, if_out, if_data_o, mem_word(ra));
        end
        if_out = 0; n_done++;
      end
      if (mem_ready_o) begin
        if (!m_we) exp_mrd = mem_word(ma);
        checks++;
        if (!m_out || mem_rdata_o !== exp_mrd) begin
          errors++; $display("FAIL rnd_mem_ready cyc=%0d: got out=%b data=%h want 1/%h", cyc, m_out, mem_rdata_o, exp_mrd);
        end
        m_out = 0; n_done++;
      end
      if (if_out) if_age++; else if_age = 0;
      if (m_out)  m_age++;  else m_age = 0;
      if (if_age == 15 || m_age == 15) begin
        checks++; errors++;
        $display("FAIL rnd_stuck cyc=%0d: got if_age=%0d m_age=%0d want <15", cyc, if_age, m_age);
      end
      if (!if_out && !stop && $urandom_range(0, 2) == 0) begin
        if_out = 1; n_issue++; ra = $urandom & 32'hFFFF_FFFC;
      end
      if (!m_out && !stop && $urandom_range(0, 3) == 0) begin
        m_out = 1; n_issue++;
        m_we = 1'($urandom_range(0, 1)); ma = $urandom & 32'hFFFF_FFFC;
        mwd = $urandom; msel = 4'($urandom_range(1, 15));
      end
      if_ce_i = if_out; if_addr_i = if_out ? ra : $urandom;
      mem_ce_i = m_out; mem_we_i = m_we; mem_addr_i = ma; mem_wdata_i = mwd; mem_sel_i = msel;
      // a request re-issued in its port's ready cycle is not eligible yet
      if_elig = if_out & ~if_ready_o;
      m_elig  = m_out  & ~mem_ready_o;
    end
    checks++;
    if (bad_stall != 0) begin
      errors++; $display("FAIL rnd_stall: got %0d bad cycles want 0", bad_stall);
    end
    checks++;
    if (n_issue != n_done || if_out || m_out) begin
      errors++; $display("FAIL rnd_complete: got done=%0d pending=%b%b want done=%0d pending=00", n_done, if_out, m_out, n_issue);
    end
    rand_dly = 1'b0;
    if_ce_i = 1'b0; mem_ce_i = 1'b0;
    cycle();
  endtask

  initial begin
    in_txn = 0; txn_start = 0; no_ack = 0; idle_ack = 0; rand_dly = 0; rd_ov_en = 0;
    wt = 0; ack_dly = 0; rd_ov = 0; n_if_rdy = 0; n_mem_rdy = 0; exp_mrd = 0;
    t_we = 0; t_addr = 0; t_wd = 0; t_sel = 0;
    test_reset();
    test_if_alone();
    test_simultaneous();
    test_mem_write();
    test_timeout();
    test_reset_mid();
    test_repeat();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
